// File: rtl/cordic_nco_sched.sv
`default_nettype none
// ============================================================================
// Module   : cordic_nco_sched
// Brief    : Round-robin scheduler sharing one CORDIC pipeline among N NCOs.
// Revision : 1.0
// ============================================================================
module cordic_nco_sched #(
    parameter  int N_CH       = 4,
    parameter  int PH_W       = 20,
    parameter  int CORDIC_LAT = 23,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PH_W-1:0]     cfg_freq,
    input  logic                cfg_clr,
    input  logic [N_CH-1:0]     req,
    output logic [N_CH-1:0]     grant,
    output logic [PH_W-1:0]     cordic_phase,
    input  logic signed [17:0]  cordic_sin,
    input  logic signed [17:0]  cordic_cos,
    output logic                out_valid,
    output logic [CH_W-1:0]     out_ch,
    output logic signed [17:0]  out_sin,
    output logic signed [17:0]  out_cos,
    output logic                busy
);

    logic [PH_W-1:0]       freq [N_CH];
    logic [PH_W-1:0]       acc  [N_CH];
    logic [CH_W-1:0]       last_grant;
    logic                  gnt_vld;
    logic [CH_W-1:0]       gnt_ch;
    logic [CORDIC_LAT-1:0] tag_vld;
    logic [CH_W-1:0]       tag_ch [CORDIC_LAT];

    logic                  sel_vld;
    logic [CH_W-1:0]       sel_ch;
    logic [CH_W-1:0]       cand;

    // First requester found scanning upward from last_grant+1, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_ch  = '0;
        cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            cand = CH_W'((int'(last_grant) + i) % N_CH);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_ch  = cand;
            end
        end
    end

    // A clear issued in the same cycle as an increment overrides it (later NBA wins).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++) begin
                freq[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            if (sel_vld)
                acc[sel_ch] <= acc[sel_ch] + freq[sel_ch];
            if (cfg_we)
                freq[cfg_ch] <= cfg_freq;
            if (cfg_clr)
                acc[cfg_ch] <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant   <= CH_W'(N_CH - 1);
            grant        <= '0;
            gnt_vld      <= 1'b0;
            gnt_ch       <= '0;
            cordic_phase <= '0;
        end else begin
            grant   <= N_CH'(sel_vld) << sel_ch;
            gnt_vld <= sel_vld;
            gnt_ch  <= sel_ch;
            if (sel_vld) begin
                last_grant   <= sel_ch;
                cordic_phase <= acc[sel_ch];
            end
        end
    end

    // Tag line is fed from the registered grant so its tail meets the CORDIC result.
    always_ff @(posedge clk) begin
        if (!rst)
            tag_vld <= '0;
        else
            tag_vld <= {tag_vld[CORDIC_LAT-2:0], gnt_vld};
    end

    always_ff @(posedge clk) begin
        tag_ch[0] <= gnt_ch;
        for (int i = 1; i < CORDIC_LAT; i++)
            tag_ch[i] <= tag_ch[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sin   <= '0;
            out_cos   <= '0;
        end else begin
            out_valid <= tag_vld[CORDIC_LAT-1];
            if (tag_vld[CORDIC_LAT-1]) begin
                out_ch  <= tag_ch[CORDIC_LAT-1];
                out_sin <= cordic_sin;
                out_cos <= cordic_cos;
            end
        end
    end

    assign busy = gnt_vld | (|tag_vld) | out_valid;

endmodule
`default_nettype wire

// File: doc/cordic_nco_sched.md
CORDIC_NCO_SCHED -- requirements
Module: cordic_nco_sched

Interface
REQ-001 Parameter N_CH, default 4: number of NCO channels sharing one CORDIC pipeline.
REQ-002 Parameter PH_W, default 20: phase and frequency word width; full scale 2^PH_W = 2*pi.
REQ-003 Parameter CORDIC_LAT, default 23: cycles from phase presented on cordic_phase to sin/cos sampled on cordic_sin/cordic_cos.
REQ-004 clk  in  1  single clock; every register updates on the rising edge.
REQ-005 rst  in  1  synchronous active-low reset, sampled on the clk rising edge.
REQ-006 cfg_we  in  1  when high, write cfg_freq into channel cfg_ch's frequency register.
REQ-007 cfg_ch  in  log2(N_CH)  target channel for the cfg_we and cfg_clr writes.
REQ-008 cfg_freq  in  PH_W  phase increment per issued sample, unsigned modulo 2^PH_W.
REQ-009 cfg_clr  in  1  when high, zero channel cfg_ch's phase accumulator.
REQ-010 req  in  N_CH  per-channel sample request level; held high to request continuous samples.
REQ-011 grant  out  N_CH  one-hot or zero; marks the channel issued this cycle (registered).
REQ-012 cordic_phase  out  PH_W  phase driven to the CORDIC phase_in (registered).
REQ-013 cordic_sin, cordic_cos  in  18 each  signed CORDIC results.
REQ-014 out_valid  out  1  result strobe; out_ch, out_sin and out_cos are valid when high.
REQ-015 out_ch  out  log2(N_CH)  channel that owns the result.
REQ-016 out_sin, out_cos  out  18 each  signed results passed through from the CORDIC.
REQ-017 busy  out  1  high while any issued sample is still in flight.

Function
REQ-018 Per channel: a frequency register freq[c] and a phase accumulator acc[c], both PH_W bits.
REQ-019 Arbitration: each cycle, grant at most one channel with req high, round-robin.
- Search starts at last_grant+1 and wraps modulo N_CH.
- last_grant updates only on a grant.
REQ-020 Issue: when channel c is granted at edge k, the following hold after edge k.
- cordic_phase = acc[c] (value before the add).
- acc[c] = acc[c] + freq[c], wrapping modulo 2^PH_W.
- grant[c] = 1.
REQ-021 No grant: grant = 0, cordic_phase holds its last value, and no tag is launched.
REQ-022 Tag pipeline: a CORDIC_LAT-deep shift register of {valid, ch}.
- On a grant it loads {1, c}; otherwise it loads {0, x}.
- It advances every cycle.
REQ-023 Output timing: out_valid, out_ch, out_sin and out_cos register the tag tail and the CORDIC results together.
- Result for an issue at edge k appears after edge k+CORDIC_LAT+1.
- Throughput: 1 sample/cycle; no output backpressure.
REQ-024 When out_valid = 0, out_sin and out_cos hold their previous values.
REQ-025 busy = OR of all valid bits in the tag pipeline plus the output stage.
REQ-026 cfg_we and a grant to the same channel in the same cycle:
- the issue uses the old freq;
- the new freq applies from the next issue.
REQ-027 cfg_clr and a grant to the same channel in the same cycle:
- cordic_phase = old acc;
- acc ends at 0; clear wins over increment.
REQ-028 cfg_we and cfg_clr together both take effect.
REQ-029 req dropping mid-stream stops new issues only; samples already in flight still emerge.

Reset
REQ-030 While rst = 0 at a clk edge, the following are cleared:
- freq[*] = 0, acc[*] = 0;
- last_grant = N_CH-1, so ch0 has priority first;
- tag valids = 0;
- grant = 0, cordic_phase = 0;
- out_valid = 0, out_ch = 0, out_sin = 0, out_cos = 0, busy = 0.
REQ-031 Reset mid-operation: in-flight CORDIC data is discarded.
- out_valid stays 0 until the first post-reset issue plus CORDIC_LAT+1 cycles.

Verification
REQ-032 Single channel: freq[0] = 0x40000, req = 0001 held.
- cordic_phase sequence: 0x00000, 0x40000, 0x80000, 0xC0000, 0x00000.
- First out_valid is 24 cycles after the first grant, with out_ch = 0.
- out_cos is near +0x1FFFF and out_sin near 0, within ±8 LSB.
REQ-033 Round-robin: req = 1111 held.
- grant sequence: 0001, 0010, 0100, 1000, 0001.
- out_ch sequence: 0, 1, 2, 3, 0.
- out_valid stays high continuously once the pipeline fills.
REQ-034 Collision: cfg_we to ch2 with freq 0x10000 in the same cycle ch2 is granted with old freq 0x08000.
- Next ch2 issue phase = old + 0x08000.
- The issue after that = previous + 0x10000.
REQ-035 Clear: cfg_clr on ch1 while ch1 is granted.
- That cycle's cordic_phase = the old acc.
- ch1's next issue phase = 0x00000.
REQ-036 Reset mid-stream: rst = 0 for 1 cycle with busy = 1.
- Next cycle: out_valid = 0 and busy = 0.
- No stale out_valid appears in the following CORDIC_LAT+1 cycles.
REQ-037 Wrap: freq = 0xFFFFF, acc = 0x00002; after the issue, acc = 0x00001.
